// File: rtl/pdm_capture_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pdm_capture_pkg -- capture FSM state encoding and level-width helper. Rev 1.0
// ----------------------------------------------------------------------------
package pdm_capture_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2
    } state_t;

    function automatic int level_width(input int word_width);
        return $clog2(word_width + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pdm_clk_gen.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pdm_clk_gen -- free-running microphone clock divider and sample strobe. Rev 1.0
// ----------------------------------------------------------------------------
module pdm_clk_gen #(
    parameter int CLK_DIV_HALF = 25
) (
    input  logic clk,
    input  logic resetn,
    output logic pdm_clk,
    output logic strobe
);

    localparam int DIV_W = (CLK_DIV_HALF > 1) ? $clog2(CLK_DIV_HALF) : 1;

    logic [DIV_W-1:0] div;
    logic             half_done;

    assign half_done = (div == DIV_W'(CLK_DIV_HALF - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            div     <= '0;
            pdm_clk <= 1'b0;
        end else if (half_done) begin
            div     <= '0;
            pdm_clk <= ~pdm_clk;
        end else begin
            div     <= div + DIV_W'(1);
        end
    end

    // Strobe is high in the cycle whose closing edge raises pdm_clk.
    assign strobe = half_done & ~pdm_clk;

endmodule
`default_nettype wire

// File: rtl/pdm_capture.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pdm_capture -- PDM microphone bit packer writing words into a capture buffer.
// Optional level output enabled by PDM_CAPTURE_LEVEL_EN.               Rev 1.0
// ----------------------------------------------------------------------------
module pdm_capture
    import pdm_capture_pkg::*;
#(
    parameter int WORD_WIDTH   = 16,
    parameter int ADDR_WIDTH   = 16,
    parameter int MEM_DEPTH    = 65536,
    parameter int CLK_DIV_HALF = 25
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  continuous,
    input  logic                  PDM_in,
    output logic                  pdm_clk,
    output logic                  pdm_lrsel,
    output logic [ADDR_WIDTH-1:0] write_address,
    output logic                  write_enable,
    output logic [WORD_WIDTH-1:0] write_data,
    output logic                  busy,
    output logic                  done,
    output logic                  wrapped
`ifdef PDM_CAPTURE_LEVEL_EN
    ,
    output logic [level_width(WORD_WIDTH)-1:0] level
`endif
);

    localparam int BIT_W = $clog2(WORD_WIDTH);

    state_t                state;
    state_t                state_nxt;
    logic                  strobe;
    logic                  cont_mode;
    logic [WORD_WIDTH-2:0] shift;
    logic [BIT_W-1:0]      bit_idx;
    logic [ADDR_WIDTH-1:0] ptr;
    logic [WORD_WIDTH-1:0] next_word;
    logic                  start_ok;
    logic                  last_write;

    pdm_clk_gen #(
        .CLK_DIV_HALF(CLK_DIV_HALF)
    ) u_clk_gen (
        .clk    (clk),
        .resetn (resetn),
        .pdm_clk(pdm_clk),
        .strobe (strobe)
    );

    assign pdm_lrsel  = 1'b0;
    assign busy       = (state == CAPTURE);
    assign done       = (state == DONE);
    assign next_word  = {shift, PDM_in};
    // Stop beats start, and a start while capturing is ignored.
    assign start_ok   = start & ~stop & (state != CAPTURE);
    assign last_write = write_enable & (write_address == ADDR_WIDTH'(MEM_DEPTH - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (start_ok) state_nxt = CAPTURE;
            end
            CAPTURE: begin
                if (stop)                          state_nxt = IDLE;
                else if (last_write && !cont_mode) state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cont_mode     <= 1'b0;
            shift         <= '0;
            bit_idx       <= '0;
            ptr           <= '0;
            write_address <= '0;
            write_enable  <= 1'b0;
            write_data    <= '0;
            wrapped       <= 1'b0;
`ifdef PDM_CAPTURE_LEVEL_EN
            level         <= '0;
`endif
        end else begin
            write_enable <= 1'b0;
            if (start_ok) begin
                cont_mode     <= continuous;
                shift         <= '0;
                bit_idx       <= '0;
                ptr           <= '0;
                write_address <= '0;
                wrapped       <= 1'b0;
            end else if (state == CAPTURE && !stop) begin
                // Wrapped rises the cycle after the top address is written.
                if (last_write && cont_mode) wrapped <= 1'b1;
                if (strobe) begin
                    shift <= next_word[WORD_WIDTH-2:0];
                    if (bit_idx == BIT_W'(WORD_WIDTH - 1)) begin
                        bit_idx       <= '0;
                        write_enable  <= 1'b1;
                        write_data    <= next_word;
                        write_address <= ptr;
                        ptr           <= (ptr == ADDR_WIDTH'(MEM_DEPTH - 1)) ? '0
                                                                             : ptr + ADDR_WIDTH'(1);
`ifdef PDM_CAPTURE_LEVEL_EN
                        level         <= level_width(WORD_WIDTH)'($countones(next_word));
`endif
                    end else begin
                        bit_idx <= bit_idx + BIT_W'(1);
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/pdm_capture.md
PDM_CAPTURE -- requirements
Module: pdm_capture

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 16: bits packed per memory word (4..32).
REQ-002 SHALL have parameter ADDR_WIDTH, default 16: write address width.
REQ-003 SHALL have parameter MEM_DEPTH, default 65536: words per capture (2..2**ADDR_WIDTH).
REQ-004 SHALL have parameter CLK_DIV_HALF, default 25: clk cycles per pdm_clk half-period (>=2).
REQ-005 SHALL have port clk, input, 1 bit: single clock, all logic on rising edge.
REQ-006 SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port start, input, 1 bit: one-cycle capture request.
REQ-008 SHALL have port stop, input, 1 bit: one-cycle abort request.
REQ-009 SHALL have port continuous, input, 1 bit: 1 = wrap-around ring capture, 0 = single-shot; sampled on the accepted start.
REQ-010 SHALL have port PDM_in, input, 1 bit: microphone data.
REQ-011 SHALL have port pdm_clk, output, 1 bit: microphone clock.
REQ-012 SHALL have port pdm_lrsel, output, 1 bit: constant 0.
REQ-013 SHALL have port write_address, output, ADDR_WIDTH bits: buffer port A address.
REQ-014 SHALL have port write_enable, output, 1 bit: one-cycle write strobe.
REQ-015 SHALL have port write_data, output, WORD_WIDTH bits: packed word.
REQ-016 SHALL have ports busy, done, wrapped: output, 1 bit each; status flags.

Function
REQ-017 SHALL toggle pdm_clk every CLK_DIV_HALF clk cycles, free-running from reset release regardless of state.
REQ-018 SHALL generate an internal sample strobe on the clk cycle in which pdm_clk goes 0->1, and register PDM_in only on that cycle.
REQ-019 SHALL use FSM states IDLE, CAPTURE, DONE; IDLE->CAPTURE on start, CAPTURE->DONE after last word in single-shot, CAPTURE->IDLE on stop, DONE->CAPTURE on start.
REQ-020 SHALL pack samples MSB-first: first strobe after entering CAPTURE fills bit WORD_WIDTH-1, the WORD_WIDTH-th fills bit 0.
REQ-021 SHALL pulse write_enable for one cycle, the cycle after the WORD_WIDTH-th strobe, with write_data and write_address stable in that cycle.
REQ-022 SHALL write the first word of each capture to address 0, then increment by 1 after each write.
REQ-023 Single-shot: after the write to MEM_DEPTH-1 SHALL enter DONE, set done, and stop writing.
REQ-024 Continuous: after the write to MEM_DEPTH-1 SHALL wrap to 0, set sticky wrapped, and continue.
REQ-025 SHALL assert busy exactly in CAPTURE.
REQ-026 stop in CAPTURE SHALL discard the partial word, issue no write, and return to IDLE next cycle; write_address holds its value.
REQ-027 start and stop in the same cycle: stop SHALL win; start in CAPTURE SHALL be ignored.
REQ-028 Accepted start SHALL clear done, wrapped, bit index and address.
REQ-029 A start coinciding with a sample strobe SHALL NOT count that strobe's sample.

Reset
REQ-030 On resetn low SHALL force: state IDLE, pdm_clk 0, divider 0, write_address 0, write_enable 0, write_data 0, busy 0, done 0, wrapped 0, level 0.
REQ-031 Reset asserted mid-capture SHALL abort with no further write_enable pulse.

Configuration
REQ-032 With PDM_CAPTURE_LEVEL_EN defined SHALL add output level, $clog2(WORD_WIDTH+1) bits, = count of ones in write_data, updated with each write_enable.
REQ-033 Without PDM_CAPTURE_LEVEL_EN the level port and popcount logic SHALL be absent.

Structure
REQ-034 Package pdm_capture_pkg SHALL hold the FSM state enum and the level width function.
REQ-035 Sub-module pdm_clk_gen SHALL implement pdm_clk and the sample strobe.

Verification (WORD_WIDTH=4, MEM_DEPTH=4, CLK_DIV_HALF=2)
REQ-036 Reset release -> pdm_clk period 4 clk cycles, first rise 2 cycles after release; all outputs 0.
REQ-037 start, continuous=0, PDM_in pattern 1,0,1,1 per strobe -> write_enable at address 0 with data 4'b1011, one cycle after the 4th strobe.
REQ-038 Single-shot, 16 strobes -> writes to addresses 0,1,2,3, then done=1, busy=0, no fifth write.
REQ-039 continuous=1, 20 strobes -> addresses 0,1,2,3,0; wrapped=1 from the fifth write.
REQ-040 stop after 2 strobes -> no write, IDLE, write_address 0; start+stop same cycle -> stays IDLE.
REQ-041 With PDM_CAPTURE_LEVEL_EN, data 4'b1011 -> level=3; resetn low mid-capture -> no write_enable.
